// File: rtl/layer_write_bank_sequencer.sv
// layer_write_bank_sequencer
//   Steers a stream of write strobes into NUM_BANKS memory banks of
//   BANK_DEPTH entries each, for one "layer" at a time.  In auto mode the
//   banks are filled strictly in order 1..NUM_BANKS; in manual mode the
//   caller picks the bank with write_sel and may fill them in any order.
//   layer_done pulses for one cycle after the write that fills the last bank.
//
//   Optional build macro: LAYER_WRITE_ERR_EN enables the sticky protocol
//   error flag on err.  Without it err is a constant 0 and no error logic
//   exists.
//
//   Write handshake: write_signal is a one-cycle strobe with no back-pressure.
//   A strobe is accepted only in RUN, when a target bank exists and that bank
//   is not full, and never in a start cycle.  Acceptance is visible in the
//   same cycle as the matching mem_write bit and mem_addr; refused strobes
//   are dropped (and flagged on err when error checking is built in).
module layer_write_bank_sequencer #(
    parameter  int NUM_BANKS  = 5,
    parameter  int BANK_DEPTH = 64,
    localparam int SEL_W      = $clog2(NUM_BANKS + 1),
    localparam int ADDR_W     = $clog2(BANK_DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     write_sel,
    input  logic                 write_signal,
    output logic [NUM_BANKS-1:0] mem_write,
    output logic [ADDR_W-1:0]    mem_addr,
    output logic [SEL_W-1:0]     cur_bank,
    output logic                 busy,
    output logic                 layer_done,
    output logic                 err,
    output logic [1:0]           state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Counter value meaning "bank full", and the value just before it.
    localparam logic [ADDR_W:0]  FULL_CNT = (ADDR_W + 1)'(BANK_DEPTH);
    localparam logic [ADDR_W:0]  LAST_CNT = (ADDR_W + 1)'(BANK_DEPTH - 1);
    localparam logic [ADDR_W:0]  CNT_ONE  = (ADDR_W + 1)'(1);
    localparam logic [SEL_W-1:0] NB_SEL   = SEL_W'(NUM_BANKS);
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);

    state_t             state_q;
    state_t             state_d;
    logic               mode_q;          // 1 = auto, latched at start
    logic [SEL_W-1:0]   cur_bank_q;
    logic               layer_done_q;
    logic [ADDR_W:0]    cnt_q [NUM_BANKS];

    logic [SEL_W-1:0]     tgt;           // target bank number, 0 = none
    logic [NUM_BANKS-1:0] tgt_hot;       // one-hot of target bank
    logic [ADDR_W:0]      tgt_cnt;       // counter of target bank
    logic                 tgt_full;
    logic                 accept;
    logic                 all_full_after;
    logic                 finish;        // accepted write completes the layer
    logic                 advance;       // auto mode moves to the next bank

    // Resolve the target bank, decide acceptance and detect end of layer.
    always_comb begin
        tgt            = '0;
        tgt_hot        = '0;
        tgt_cnt        = '0;
        tgt_full       = 1'b0;
        accept         = 1'b0;
        all_full_after = 1'b1;
        finish         = 1'b0;
        advance        = 1'b0;

        // A start cycle never writes: the counters are about to be cleared.
        if (state_q == S_RUN && !start) begin
            if (mode_q) begin
                tgt = cur_bank_q;
            end else if (write_sel != '0 && write_sel <= NB_SEL) begin
                tgt = write_sel;
            end
        end

        for (int b = 0; b < NUM_BANKS; b++) begin
            if (tgt == SEL_W'(b + 1)) begin
                tgt_hot[b] = 1'b1;
                tgt_cnt    = cnt_q[b];
            end
        end

        tgt_full = (tgt_hot != '0) && (tgt_cnt == FULL_CNT);
        accept   = write_signal && (tgt_hot != '0) && !tgt_full;

        // The layer ends when, after this write, every bank is full.
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (!((cnt_q[b] == FULL_CNT) ||
                  (accept && tgt_hot[b] && cnt_q[b] == LAST_CNT))) begin
                all_full_after = 1'b0;
            end
        end

        if (mode_q) begin
            finish  = accept && (tgt_cnt == LAST_CNT) && (cur_bank_q == NB_SEL);
            advance = accept && (tgt_cnt == LAST_CNT) && (cur_bank_q != NB_SEL);
        end else begin
            finish  = accept && all_full_after;
        end
    end

    assign mem_write = accept ? tgt_hot : '0;
    assign mem_addr  = tgt_cnt[ADDR_W-1:0];

    // Next-state logic; start wins from any state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_IDLE;
            S_RUN:  if (finish) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (start) begin
            state_d = S_RUN;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Mode, active bank and the registered end-of-layer pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q       <= 1'b0;
            cur_bank_q   <= '0;
            layer_done_q <= 1'b0;
        end else begin
            layer_done_q <= (state_d == S_DONE);
            if (start) begin
                mode_q     <= mode;
                cur_bank_q <= SEL_ONE;
            end else if (advance) begin
                cur_bank_q <= cur_bank_q + SEL_ONE;
            end
        end
    end

    // Per-bank fill counters: cleared by start, bumped by accepted writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                cnt_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                if (start) begin
                    cnt_q[b] <= '0;
                end else if (mem_write[b]) begin
                    cnt_q[b] <= cnt_q[b] + CNT_ONE;
                end
            end
        end
    end

`ifdef LAYER_WRITE_ERR_EN
    logic err_q;
    logic err_set;

    // A strobe outside RUN, with no legal target, or into a full bank is an error.
    always_comb begin
        err_set = 1'b0;
        if (write_signal && !start) begin
            err_set = (state_q != S_RUN) || (tgt_hot == '0) || tgt_full;
        end
    end

    // Sticky error flag, cleared only by start or reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (start) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign busy       = (state_q == S_RUN);
    assign cur_bank   = busy ? cur_bank_q : '0;
    assign layer_done = layer_done_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_layer_write_bank_sequencer.sv
// Bench for layer_write_bank_sequencer with NUM_BANKS=5, BANK_DEPTH=4.
// The driver applies one input vector per cycle and pushes the outputs a
// behavioural layer model predicts for that cycle; the monitor pops and
// compares them in the same cycle.  Honours LAYER_WRITE_ERR_EN for err.
module tb_layer_write_bank_sequencer;
  localparam int NB    = 5;
  localparam int DEPTH = 4;
`ifdef LAYER_WRITE_ERR_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] write_sel = '0;
  logic       write_signal = 1'b0;
  logic [4:0] mem_write;
  logic [1:0] mem_addr;
  logic [2:0] cur_bank;
  logic       busy;
  logic       layer_done;
  logic       err;
  logic [1:0] state_dbg;

  // clock / reset
  always #5 clk = ~clk;

  layer_write_bank_sequencer #(.NUM_BANKS(NB), .BANK_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .write_sel(write_sel),
    .write_signal(write_signal), .mem_write(mem_write), .mem_addr(mem_addr),
    .cur_bank(cur_bank), .busy(busy), .layer_done(layer_done), .err(err),
    .state_dbg(state_dbg)
  );

  // reference model of one layer: fill levels, active bank, phase flags
  bit m_busy, m_done, m_auto, m_err;
  int m_cnt[NB];
  int m_bank;

  int errors = 0;
  int checks = 0;
  logic [12:0] exp_q[$];   // {mem_write, mem_addr, cur_bank, busy, layer_done, err}

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_auto = 0; m_err = 0; m_bank = 0;
    foreach (m_cnt[i]) m_cnt[i] = 0;
  endtask

  // driver: one cycle of stimulus plus its predicted response
  task automatic drive(input bit st, input bit md, input int sel, input bit ws, input bit rn);
    int tgt;
    bit wr, all_full;
    logic [4:0] e_mw;
    logic [1:0] e_ad;
    logic [2:0] e_cb;
    @(negedge clk);
    rst = rn; start = st; mode = md; write_sel = 3'(sel); write_signal = ws;
    if (!rn) begin
      model_reset();
      exp_q.push_back('0);
      return;
    end
    tgt = 0;
    if (m_busy && !st) tgt = m_auto ? m_bank : ((sel >= 1 && sel <= NB) ? sel : 0);
    wr   = ws && (tgt != 0) && (m_cnt[tgt-1] < DEPTH);
    e_mw = wr ? 5'(1 << (tgt - 1)) : 5'd0;
    e_ad = (tgt != 0) ? 2'(m_cnt[tgt-1] % DEPTH) : 2'd0;
    e_cb = m_busy ? 3'(m_bank) : 3'd0;
    exp_q.push_back({e_mw, e_ad, e_cb, m_busy, m_done, m_err});
    if (st) begin
      m_busy = 1; m_done = 0; m_auto = md; m_bank = 1; m_err = 0;
      foreach (m_cnt[i]) m_cnt[i] = 0;
    end else begin
      if (ERR_ON && ws && (!m_busy || tgt == 0 || m_cnt[tgt-1] >= DEPTH)) m_err = 1;
      m_done = 0;
      if (wr) begin
        m_cnt[tgt-1]++;
        all_full = 1;
        foreach (m_cnt[i]) if (m_cnt[i] < DEPTH) all_full = 0;
        if (all_full) begin
          m_busy = 0; m_done = 1;
        end else if (m_auto && m_cnt[tgt-1] == DEPTH) begin
          m_bank++;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // scoreboard monitor: compare whatever the DUT presents this cycle
  always @(negedge clk) begin
    logic [12:0] e;
    #2;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("mem_write",  32'(mem_write),  32'(e[12:8]));
      chk("mem_addr",   32'(mem_addr),   32'(e[7:6]));
      chk("cur_bank",   32'(cur_bank),   32'(e[5:3]));
      chk("busy",       32'(busy),       32'(e[2]));
      chk("layer_done", 32'(layer_done), 32'(e[1]));
      chk("err",        32'(err),        32'(e[0]));
    end
  end

  initial begin
    int ord[5];
    bit st, rn;
    ord = '{3, 1, 5, 2, 4};
    model_reset();
    // reset state
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    // strobes while idle are ignored
    drive(0, 0, 3, 1, 1);
    drive(0, 1, 0, 0, 1);
    // start with a coincident write, a few writes, then restart mid-layer
    drive(1, 1, 2, 1, 1);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, 1, 1);
    drive(1, 1, 0, 1, 1);
    // auto: 20 consecutive writes with mode wiggling mid-layer
    for (int i = 0; i < 20; i++) drive(0, 1'($urandom_range(0, 1)), 0, 1, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1);
    // manual: banks 3,1,5,2,4; extra write to full bank 2; illegal selects
    drive(1, 0, 0, 0, 1);
    drive(0, 1, 0, 1, 1);
    drive(0, 1, 6, 1, 1);
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 4; k++) drive(0, 1'($urandom_range(0, 1)), ord[i], 1, 1);
      if (i == 3) drive(0, 0, 2, 1, 1);
    end
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 0, 1);
    // auto: 9 writes, reset for a cycle, restart
    drive(1, 1, 0, 0, 1);
    for (int i = 0; i < 9; i++) drive(0, 1, 0, 1, 1);
    drive(0, 1, 0, 1, 0);
    drive(0, 1, 0, 1, 1);
    drive(1, 1, 0, 1, 1);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 1, 1);
    // randomized layers
    for (int i = 0; i < 1500; i++) begin
      st = (!m_busy && $urandom_range(0, 4) == 0) || ($urandom_range(0, 90) == 0);
      rn = ($urandom_range(0, 300) != 0);
      drive(st, 1'($urandom_range(0, 1)),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(1, 5)),
            ($urandom_range(0, 9) < 8), rn);
    end
    drive(0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
